pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed M->W pipeline register: carries instruction, PC and a configurable payload between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so `in_ready` is a register output and back-pressure never forms a combinational path through the stage.
- Supports a synchronous flush on exception request, which injects a bubble tagged with the exception-vector PC.
- One instance is placed per stage boundary: F/D, D/E, E/M and M/W.

Parameters:
- PAYLOAD_W, 128, width of the opaque per-stage payload (ALU, DM, MDU and CP0 results, flags).
- RESET_PC, 32'h0000_3000, value of `out_pc` after reset.
- EXC_PC, 32'h0000_4180, value of `out_pc` after flush.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  exception request; synchronous; discards all held beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- in_payload  in  PAYLOAD_W  stage results
- out_valid  out  1  head beat present
- out_ready  in  1  downstream accepts head beat
- out_instr  out  32  head instruction; reads 0 (nop) when out_valid=0
- out_pc  out  32  head PC
- out_payload  out  PAYLOAD_W  head payload
- occupancy  out  2  number of beats held (0..2)

Behaviour:
- Storage: main entry (drives `out_*`) plus skid entry. Each entry has a valid bit.
- Handshakes:
  - accept = `in_valid & in_ready`.
  - deliver = `out_valid & out_ready`.
  - `out_valid` = main.valid.
  - `in_ready` = !skid.valid, registered.
- States (encoded by occupancy):
  - EMPTY (0):
    - accept -> ONE; the beat loads main.
  - ONE (1):
    - accept & deliver -> ONE; main is replaced by the new beat.
    - accept & !deliver -> FULL; the beat loads skid.
    - !accept & deliver -> EMPTY.
    - Otherwise hold.
  - FULL (2), `in_ready`=0:
    - deliver -> ONE; skid moves to main.
    - Otherwise hold.
  - In FULL, `in_valid` is ignored; no accept is possible.
- Ordering: strict FIFO; beats are never duplicated or dropped except by flush or reset.
- Latency:
  - A beat accepted into EMPTY appears on `out_*` the next cycle.
  - Throughput is 1 beat/cycle when `out_ready`=1.
- Data fields when empty:
  - `out_pc` and `out_payload` hold the last loaded value when main is empty.
  - `out_instr` is masked to 0 whenever `out_valid`=0.
- Reset (highest priority), next cycle:
  - occupancy=0, `out_valid`=0, `in_ready`=1.
  - `out_instr`=0, `out_pc`=RESET_PC, `out_payload`=0.
  - Skid contents are cleared.
- Flush (below reset, above handshakes), next cycle:
  - Same as reset except `out_pc`=EXC_PC.
  - A beat offered on the flush cycle is dropped, even when `in_ready`=1.
  - A deliver on the flush cycle is still counted as delivered by the consumer; the stage itself discards its copy.
- Reset or flush mid-FULL: both entries are discarded; `in_ready` is 1 the next cycle.
- Flush held for multiple cycles: the stage stays EMPTY with `out_pc`=EXC_PC.
- No arithmetic is performed on data; all fields pass through bit-exact.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, two output ports are added:
  - `stall_cnt` [CNT_W-1:0]: increments each cycle with `out_valid & !out_ready`.
  - `bubble_cnt` [CNT_W-1:0]: increments each cycle with `!out_valid & !reset`, and on every flush cycle.
- Both counters saturate at all-ones and clear on reset only; flush does not clear them.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: pulse reset -> `out_valid`=0, `out_instr`=0, `out_pc`=32'h3000, `in_ready`=1, occupancy=0.
- Streaming: 4 beats with PC 3000..300C, `out_ready`=1 every cycle -> each beat appears 1 cycle after accept in order, occupancy stays 1, `in_ready` never drops.
- Back-pressure: `out_ready`=0, offer beats PC 3000 and 3004 -> occupancy=2 and `in_ready`=0 on the next cycle; a third beat (3008) is not accepted. Raise `out_ready` -> outputs 3000, then 3004, then 3008 in consecutive cycles.
- Flush with FULL and a new beat offered: flush=1 -> next cycle occupancy=0, `out_pc`=32'h4180, `out_instr`=0, and the offered beat never appears.
- Reset and flush together: both asserted -> `out_pc`=32'h3000 (reset wins).
- With PIPE_STAGE_PERF_EN and CNT_W=4: hold `out_valid`=1 with `out_ready`=0 for 20 cycles -> `stall_cnt`=4'hF (saturated); a subsequent flush leaves `stall_cnt`=4'hF.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and exception flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int          PAYLOAD_W = 128,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
`endif
  output logic [1:0]           occupancy
);

  logic                 main_valid_q, main_valid_d;
  logic [31:0]          main_instr_q, main_instr_d;
  logic [31:0]          main_pc_q, main_pc_d;
  logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [31:0]          skid_instr_q, skid_instr_d;
  logic [31:0]          skid_pc_q, skid_pc_d;
  logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
  logic                 in_ready_q;
  logic                 accept, deliver;

  assign accept  = in_valid & in_ready_q;
  assign deliver = main_valid_q & out_ready;

  always_comb begin
    main_valid_d   = main_valid_q;
    main_instr_d   = main_instr_q;
    main_pc_d      = main_pc_q;
    main_payload_d = main_payload_q;
    skid_valid_d   = skid_valid_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    skid_payload_d = skid_payload_q;
    if (reset || flush) begin
      main_valid_d   = 1'b0;
      main_instr_d   = '0;
      main_pc_d      = reset ? RESET_PC : EXC_PC;
      main_payload_d = '0;
      skid_valid_d   = 1'b0;
      skid_instr_d   = '0;
      skid_pc_d      = '0;
      skid_payload_d = '0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d   = 1'b1;
        main_instr_d   = in_instr;
        main_pc_d      = in_pc;
        main_payload_d = in_payload;
      end
    end else if (skid_valid_q) begin
      // FULL: in_ready is low, so only a deliver can move the skid beat forward
      if (deliver) begin
        main_instr_d   = skid_instr_q;
        main_pc_d      = skid_pc_q;
        main_payload_d = skid_payload_q;
        skid_valid_d   = 1'b0;
      end
    end else begin
      if (accept && deliver) begin
        main_instr_d   = in_instr;
        main_pc_d      = in_pc;
        main_payload_d = in_payload;
      end else if (accept) begin
        skid_valid_d   = 1'b1;
        skid_instr_d   = in_instr;
        skid_pc_d      = in_pc;
        skid_payload_d = in_payload;
      end else if (deliver) begin
        main_valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    main_valid_q   <= main_valid_d;
    main_instr_q   <= main_instr_d;
    main_pc_q      <= main_pc_d;
    main_payload_q <= main_payload_d;
    skid_valid_q   <= skid_valid_d;
    skid_instr_q   <= skid_instr_d;
    skid_pc_q      <= skid_pc_d;
    skid_payload_q <= skid_payload_d;
    // Registered copy keeps back-pressure from forming a combinational path
    in_ready_q     <= !skid_valid_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_instr   = main_valid_q ? main_instr_q : 32'h0;
  assign out_pc      = main_pc_q;
  assign out_payload = main_payload_q;
  assign occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((!main_valid_q || flush) && !(&bubble_cnt_q))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue-based FIFO model (capacity 2) predicts every output.
module tb_pipe_stage_skid;
  localparam int          PW       = 128;
  localparam int          CW       = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_instr, in_pc, out_instr, out_pc;
  logic [PW-1:0] in_payload, out_payload;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
  int            stall_m = 0, bubble_m = 0;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.PAYLOAD_W(PW), .RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_payload(out_payload),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [PW-1:0] pay;
  } beat_t;

  beat_t         sb[$];
  int            checks = 0, errors = 0;
  bit            started = 1'b0;
  logic [31:0]   idle_pc;
  logic [PW-1:0] idle_pay;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model is updated at the edge from what was driven.
  task automatic step(input bit iv, input bit ordy, input bit fl, input bit rst, input logic [31:0] pc);
    beat_t b;
    bit    acc;
    int    occ;
    b.instr = $urandom;
    b.pc    = pc;
    b.pay   = {$urandom, $urandom, $urandom, $urandom};
    in_valid = iv; in_instr = b.instr; in_pc = b.pc; in_payload = b.pay;
    out_ready = ordy; flush = fl; reset = rst;
    occ = sb.size();
    acc = iv && (occ < 2);
    @(posedge clk);
    if (rst) begin
      sb.delete(); idle_pc = RESET_PC; idle_pay = '0;
    end else if (fl) begin
      sb.delete(); idle_pc = EXC_PC; idle_pay = '0;
    end else if (acc) begin
      sb.push_back(b);
    end
`ifdef PIPE_STAGE_PERF_EN
    if (rst) begin
      stall_m = 0; bubble_m = 0;
    end else begin
      if (occ > 0 && !ordy && stall_m < (1 << CW) - 1) stall_m++;
      if ((occ == 0 || fl) && bubble_m < (1 << CW) - 1) bubble_m++;
    end
`endif
    started = 1'b1;
    #1;
  endtask

  // Monitor: compares DUT state against the model and retires delivered beats.
  always @(negedge clk) begin
    if (started) begin
      check("occupancy", occupancy, sb.size());
      check("in_ready", in_ready, sb.size() < 2);
      check("out_valid", out_valid, sb.size() > 0);
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", stall_cnt, stall_m);
      check("bubble_cnt", bubble_cnt, bubble_m);
`endif
      if (sb.size() > 0) begin
        check("out_instr", out_instr, sb[0].instr);
        check("out_pc", out_pc, sb[0].pc);
        check("out_payload", out_payload, sb[0].pay);
        if (out_ready && !reset) begin
          $display("deliver pc=%08h instr=%08h t=%0t", sb[0].pc, sb[0].instr, $time);
          idle_pc  = sb[0].pc;
          idle_pay = sb[0].pay;
          void'(sb.pop_front());
        end
      end else begin
        check("idle_instr", out_instr, '0);
        check("idle_pc", out_pc, idle_pc);
        check("idle_payload", out_payload, idle_pay);
      end
    end
  end

  initial begin
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    // Streaming at full rate
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 32'h3000 + 4 * i);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // Back-pressure: fill both entries, third beat waits
    step(1, 0, 0, 0, 32'h3000);
    step(1, 0, 0, 0, 32'h3004);
    step(1, 0, 0, 0, 32'h3008);
    step(1, 1, 0, 0, 32'h3008);
    step(1, 1, 0, 0, 32'h3008);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // Flush while full with a new beat offered
    step(1, 0, 0, 0, 32'h3010);
    step(1, 0, 0, 0, 32'h3014);
    step(1, 0, 1, 0, 32'h3018);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    // Reset and flush together
    step(1, 0, 0, 0, 32'h3020);
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    // Long stall to saturate narrow counters, then flush
    step(1, 0, 0, 0, 32'h3024);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1, $urandom);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    check("drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
